// File: rtl/pkt8towide_out.sv
// Byte-stream packet to wide-word converter: header capture, MSB-first payload
// packing, trailer check and a first-word-fall-through output FIFO.
module pkt8towide_out #(
  parameter int          OUT_BYTES      = 32,
  parameter int          WHEREIS_SEGNUM = 4,
  parameter int          WHEREIS_ID     = 6,
  parameter int          ID_W           = 4,
  parameter int          PAYLOAD_OFS    = 8,
  parameter logic [7:0]  TRAILER        = 8'hAA,
  parameter int          FIFO_DEPTH     = 4,
  localparam int         NB_W           = $clog2(OUT_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   RST_N,
  input  logic                   rxen,
  input  logic [7:0]             rxd,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [NB_W-1:0]        out_nbytes,
  output logic                   out_err,
  output logic [ID_W-1:0]        out_id,
  output logic [15:0]            out_segnum,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            err_cnt
);

  localparam int W  = 8 * OUT_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic            armed, in_pkt, err, drop;
  logic [15:0]     cnt;
  logic [7:0]      hold_byte;
  logic [NB_W-1:0] pend;
  logic [W-1:0]    pack_buf;
  logic [ID_W-1:0] id_r;
  logic [15:0]     seg_r;

  logic [W-1:0]    mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];
  logic            mem_err  [FIFO_DEPTH];
  logic [NB_W-1:0] mem_nb   [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id   [FIFO_DEPTH];
  logic [15:0]     mem_seg  [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;

  logic         byte_in, pkt_end, commit, short_pkt, word_full, pop, space;
  logic         push_full, ovf, last_req, push_last, pkt_err, push;
  logic [W-1:0] word_next;

  always_comb begin
    byte_in   = rxen & armed;
    pkt_end   = ~rxen & in_pkt;
    // The held byte has index cnt-1; it is payload once that index reaches PAYLOAD_OFS.
    commit    = byte_in && (cnt > 16'(PAYLOAD_OFS));
    short_pkt = (cnt <= 16'(PAYLOAD_OFS));
    word_next = pack_buf;
    if (commit) word_next[W-8-8*int'(pend) +: 8] = hold_byte;
    word_full = commit && (pend == NB_W'(OUT_BYTES - 1));
    pop       = out_valid & out_ready;
    space     = (fifo_cnt != (AW+1)'(FIFO_DEPTH)) | pop;
    push_full = word_full & ~drop & space;
    ovf       = word_full & ~drop & ~space;
    last_req  = pkt_end & ~short_pkt;
    push_last = last_req & space;
    pkt_err   = err | (hold_byte != TRAILER) | ~space;
    push      = push_full | push_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      in_pkt    <= 1'b0;
      err       <= 1'b0;
      drop      <= 1'b0;
      cnt       <= '0;
      hold_byte <= '0;
      pend      <= '0;
      pack_buf  <= '0;
      id_r      <= '0;
      seg_r     <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      armed <= armed | ~rxen;
      if (byte_in) begin
        in_pkt    <= 1'b1;
        hold_byte <= rxd;
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        if (cnt == 16'(WHEREIS_SEGNUM))     seg_r[15:8] <= rxd;
        if (cnt == 16'(WHEREIS_SEGNUM + 1)) seg_r[7:0]  <= rxd;
        if (cnt == 16'(WHEREIS_ID))         id_r        <= rxd[ID_W-1:0];
        if (commit) begin
          if (word_full) begin
            pend     <= '0;
            pack_buf <= '0;
          end else begin
            pend     <= pend + NB_W'(1);
            pack_buf <= word_next;
          end
        end
        if (ovf) begin
          err  <= 1'b1;
          drop <= 1'b1;
        end
      end
      if (pkt_end) begin
        in_pkt   <= 1'b0;
        cnt      <= '0;
        pend     <= '0;
        pack_buf <= '0;
        err      <= 1'b0;
        drop     <= 1'b0;
        if (short_pkt || pkt_err) err_cnt <= err_cnt + 16'd1;
        else                      pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_last ? pack_buf : word_next;
      mem_last[wr_ptr] <= push_last;
      mem_err[wr_ptr]  <= push_last & pkt_err;
      mem_nb[wr_ptr]   <= push_last ? pend : NB_W'(OUT_BYTES);
      mem_id[wr_ptr]   <= id_r;
      mem_seg[wr_ptr]  <= seg_r;
    end
  end

  assign out_valid  = (fifo_cnt != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last   = out_valid & mem_last[rd_ptr];
  assign out_err    = out_valid & mem_err[rd_ptr];
  assign out_nbytes = out_valid ? mem_nb[rd_ptr]  : '0;
  assign out_id     = out_valid ? mem_id[rd_ptr]  : '0;
  assign out_segnum = out_valid ? mem_seg[rd_ptr] : '0;

endmodule

// File: tb/tb_pkt8towide_out.sv
// Scoreboard bench for pkt8towide_out: packets are modelled as byte arrays,
// expected words queued at send time and compared by a monitor on each pop.
module tb_pkt8towide_out;

  localparam int OB    = 32;
  localparam int POFS  = 8;
  localparam int DEPTH = 4;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [5:0]   nb;
    logic         err;
    logic [3:0]   id;
    logic [15:0]  seg;
  } exp_t;

  logic         clk = 0;
  logic         RST_N = 0;
  logic         rxen = 0;
  logic [7:0]   rxd = 0;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready = 1;
  logic         out_last;
  logic [5:0]   out_nbytes;
  logic         out_err;
  logic [3:0]   out_id;
  logic [15:0]  out_segnum;
  logic [15:0]  pkt_cnt, err_cnt;

  pkt8towide_out dut (
    .clk(clk), .RST_N(RST_N), .rxen(rxen), .rxd(rxd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_nbytes(out_nbytes), .out_err(out_err),
    .out_id(out_id), .out_segnum(out_segnum),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_pkt = 0;
  logic [15:0] exp_err = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Reference: derive the word list of a packet directly from its bytes.
  function automatic void model(input byte_q_t pkt, input bit stall);
    int n, p, nfull, rem, nemit;
    exp_t e;
    bit terr;
    n = pkt.size();
    if (n < POFS + 1) begin
      exp_err++;
      return;
    end
    p     = n - 1 - POFS;
    nfull = p / OB;
    rem   = p % OB;
    terr  = (pkt[n-1] != 8'hAA);
    nemit = (stall && nfull >= DEPTH) ? DEPTH : nfull;
    e.id  = pkt[6][3:0];
    e.seg = {pkt[4], pkt[5]};
    for (int k = 0; k < nemit; k++) begin
      e.data = '0;
      for (int j = 0; j < OB; j++) e.data[8*(OB-1-j) +: 8] = pkt[POFS + k*OB + j];
      e.last = 0; e.nb = 6'(OB); e.err = 0;
      sb.push_back(e);
    end
    if (stall && nfull >= DEPTH) begin
      exp_err++;
    end else begin
      e.data = '0;
      for (int j = 0; j < rem; j++) e.data[8*(OB-1-j) +: 8] = pkt[POFS + nfull*OB + j];
      e.last = 1; e.nb = 6'(rem); e.err = terr;
      sb.push_back(e);
      if (terr) exp_err++;
      else      exp_pkt++;
    end
  endfunction

  always @(negedge clk) begin
    if (RST_N && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got data %h last %b nbytes %0d, expected no word", out_data, out_last, out_nbytes);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data",   out_data,   e.data);
        chk("out_last",   256'(out_last),   256'(e.last));
        chk("out_nbytes", 256'(out_nbytes), 256'(e.nb));
        chk("out_err",    256'(out_err),    256'(e.err));
        chk("out_id",     256'(out_id),     256'(e.id));
        chk("out_segnum", 256'(out_segnum), 256'(e.seg));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 4) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  function automatic byte_q_t std_pkt(input int len, input logic [7:0] trailer);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(i + 1));
    q[4] = 8'h00; q[5] = 8'h05; q[6] = 8'h03;
    q[len-1] = trailer;
    return q;
  endfunction

  task automatic send(input byte_q_t pkt, input int gap);
    foreach (pkt[i]) begin
      @(posedge clk); #1;
      rxen = 1; rxd = pkt[i];
    end
    @(posedge clk); #1;
    rxen = 0;
    repeat (gap) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pkt_cnt"}, 256'(pkt_cnt), 256'(exp_pkt));
    chk({tag, "_err_cnt"}, 256'(err_cnt), 256'(exp_err));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_total++;
      $display("FAIL %s_drain_timeout: got %0d words outstanding, expected 0", tag, sb.size());
    end
  endtask

  initial begin
    byte_q_t p;
    repeat (3) @(negedge clk);
    chk("rst_out_valid",  256'(out_valid),  0);
    chk("rst_out_data",   out_data,         0);
    chk("rst_out_last",   256'(out_last),   0);
    chk("rst_out_nbytes", 256'(out_nbytes), 0);
    chk("rst_pkt_cnt",    256'(pkt_cnt),    0);
    chk("rst_err_cnt",    256'(err_cnt),    0);
    @(posedge clk); #1;
    RST_N = 1;
    repeat (5) @(posedge clk);

    p = std_pkt(96, 8'hAA); model(p, 0); send(p, 3); drain("good96"); check_counters("good96");
    p = std_pkt(73, 8'hAA); model(p, 0); send(p, 3); drain("len73");  check_counters("len73");
    p = std_pkt(96, 8'h55); model(p, 0); send(p, 3); drain("bad96");  check_counters("bad96");
    p = std_pkt(5, 8'hAA);  model(p, 0); send(p, 3); drain("short");  check_counters("short");
    p = std_pkt(96, 8'hAA); model(p, 0); send(p, 3); drain("after_short"); check_counters("after_short");
    p = std_pkt(9, 8'hAA);  model(p, 0); send(p, 1); drain("len9");   check_counters("len9");

    ready_mode = 2;
    repeat (2) @(posedge clk);
    p = std_pkt(200, 8'hAA); model(p, 1); send(p, 5);
    check_counters("ovf");
    chk("ovf_out_valid", 256'(out_valid), 1);
    ready_mode = 0;
    drain("ovf");

    p = std_pkt(96, 8'hAA);
    foreach (p[i]) begin
      @(posedge clk); #1;
      if (i == 40) RST_N = 0;
      if (i == 45) RST_N = 1;
      rxen = 1; rxd = p[i];
    end
    @(posedge clk); #1;
    rxen = 0;
    exp_pkt = 0; exp_err = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 256'(out_valid), 0);
    check_counters("midrst");
    p = std_pkt(96, 8'hAA); model(p, 0); send(p, 3); drain("post_rst"); check_counters("post_rst");

    ready_mode = 1;
    for (int k = 0; k < 30; k++) begin
      int len;
      len = $urandom_range(1, 150);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0) p[len-1] = 8'hAA;
      model(p, 0);
      send(p, $urandom_range(1, 4));
      check_counters("rand");
    end
    ready_mode = 0;
    drain("final");
    chk("sb_empty", 256'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
